// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: valid-qualified bit stream compared
// against a runtime-loaded 1..MAX_LEN bit pattern, with Mealy match and counter.
module seq_detect_prog #(
  parameter  int MAX_LEN   = 8,
  parameter  int CNT_WIDTH = 8,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 d,
  input  logic                 cfg_load,
  input  logic [MAX_LEN-1:0]   cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_overlap,
  input  logic                 count_clr,
  output logic                 match,
  output logic                 match_q,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 count_sat
);

  logic [MAX_LEN-1:0]   act_pat_r;
  logic [LEN_W-1:0]     act_len_r;
  logic                 act_ovl_r;
  logic [MAX_LEN-2:0]   hist_r;
  logic [LEN_W-1:0]     fill_r;

  logic [MAX_LEN-1:0]   window_s;
  logic [MAX_LEN-1:0]   mask_s;
  logic [LEN_W-1:0]     len_m1_s;
  logic [LEN_W-1:0]     len_clamp_s;
  logic [LEN_W-1:0]     fill_nxt_s;
  logic                 match_s;

  assign window_s = {hist_r, d};
  assign len_m1_s = act_len_r - LEN_W'(1);

  // Compare mask: only the low act_len bits of window and pattern take part
  always_comb begin
    mask_s = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(act_len_r));
    end
  end

  // Mealy match: needs a full history and no config load in the same cycle
  always_comb begin
    if (in_valid && !cfg_load && (fill_r >= len_m1_s)) begin
      match_s = ((window_s & mask_s) == (act_pat_r & mask_s));
    end else begin
      match_s = 1'b0;
    end
  end

  assign match = match_s;

  // Length clamp into 1..MAX_LEN
  always_comb begin
    if (cfg_len == LEN_W'(0)) begin
      len_clamp_s = LEN_W'(1);
    end else if (int'(cfg_len) > MAX_LEN) begin
      len_clamp_s = LEN_W'(MAX_LEN);
    end else begin
      len_clamp_s = cfg_len;
    end
  end

  // Fill tracking: non-overlapping mode restarts the window after a hit
  always_comb begin
    if (match_s && !act_ovl_r) begin
      fill_nxt_s = LEN_W'(0);
    end else if (fill_r < len_m1_s) begin
      fill_nxt_s = fill_r + LEN_W'(1);
    end else begin
      fill_nxt_s = len_m1_s;
    end
  end

  // Active configuration and history state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_pat_r <= MAX_LEN'(3'b101);
      act_len_r <= LEN_W'(3);
      act_ovl_r <= 1'b1;
      hist_r    <= {(MAX_LEN-1){1'b0}};
      fill_r    <= LEN_W'(0);
    end else if (cfg_load) begin
      act_pat_r <= cfg_pattern;
      act_len_r <= len_clamp_s;
      act_ovl_r <= cfg_overlap;
      hist_r    <= {(MAX_LEN-1){1'b0}};
      fill_r    <= LEN_W'(0);
    end else if (in_valid) begin
      hist_r    <= {hist_r[MAX_LEN-3:0], d};
      fill_r    <= fill_nxt_s;
    end else begin
      hist_r    <= hist_r;
      fill_r    <= fill_r;
    end
  end

  // Registered copy of the match pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_s;
    end
  end

  // Saturating match counter; clear wins over a same-cycle match
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= CNT_WIDTH'(0);
      count_sat   <= 1'b0;
    end else if (count_clr) begin
      match_count <= CNT_WIDTH'(0);
      count_sat   <= 1'b0;
    end else if (match_s) begin
      if (match_count != {CNT_WIDTH{1'b1}}) begin
        match_count <= match_count + CNT_WIDTH'(1);
      end else begin
        count_sat   <= 1'b1;
      end
    end else begin
      match_count <= match_count;
      count_sat   <= count_sat;
    end
  end

endmodule
